// File: rtl/sa_fifo_ctrl_rwsthp_80x17.sv
// FIFO controller that turns the sa_ram_rwsthp_80x17 registered-read RAM into an 80x17 valid/ready FIFO.
// Optional RAM bypass for an empty pipeline: define SA_FIFO_CTRL_BYPASS_EN.
module sa_fifo_ctrl_rwsthp_80x17 #(
    parameter int DEPTH = 80,
    parameter int WIDTH = 17,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [7:0]       fifo_cnt,
    output logic [AW-1:0]    ram_ra,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_re,
    output logic             ram_ore,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [WIDTH-1:0] ram_dbyp,
    output logic             ram_byp_sel,
    input  logic [WIDTH-1:0] ram_dout
);
    localparam int STAGES = 2;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]     wr_ptr, iss_ptr;
    logic [7:0]        ram_cnt, pending;
    logic [STAGES:1]   vld_pipe;   // [1] = RAM address register / bypass word, [2] = RAM output register
    logic              s1_byp;
    logic [WIDTH-1:0]  byp_data;
    logic              accept, adv, byp, we, re, free;

    always_comb begin
        wr_prdy = reset_ && (ram_cnt < 8'(DEPTH));
        accept  = wr_pvld && wr_prdy;
        adv     = vld_pipe[1] && (!vld_pipe[2] || rd_prdy);
        pending = ram_cnt - {7'd0, vld_pipe[1] && !s1_byp};
`ifdef SA_FIFO_CTRL_BYPASS_EN
        byp     = accept && (pending == '0) && (!vld_pipe[1] || adv);
`else
        byp     = 1'b0;
`endif
        we      = accept && !byp;
        re      = reset_ && (pending != '0) && (!vld_pipe[1] || adv);
        // A slot is released only once its address leaves s1, so M[ra_d] is stable across a stall.
        free    = adv && !s1_byp;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr   <= '0;
            iss_ptr  <= '0;
            ram_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            if (we) wr_ptr  <= (wr_ptr == LAST)  ? '0 : wr_ptr + 1'b1;
            if (re) iss_ptr <= (iss_ptr == LAST) ? '0 : iss_ptr + 1'b1;
            case ({we, free})
                2'b10:   ram_cnt <= ram_cnt + 8'd1;
                2'b01:   ram_cnt <= ram_cnt - 8'd1;
                default: ram_cnt <= ram_cnt;
            endcase
            if (re || byp)  vld_pipe[1] <= 1'b1;
            else if (adv)   vld_pipe[1] <= 1'b0;
            if (adv)          vld_pipe[2] <= 1'b1;
            else if (rd_prdy) vld_pipe[2] <= 1'b0;
        end
    end

`ifdef SA_FIFO_CTRL_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!reset_) begin
            s1_byp   <= 1'b0;
            byp_data <= '0;
        end else if (re) begin
            s1_byp   <= 1'b0;
        end else if (byp) begin
            s1_byp   <= 1'b1;
            byp_data <= wr_pd;
        end else if (adv) begin
            s1_byp   <= 1'b0;
        end
    end
`else
    assign s1_byp   = 1'b0;
    assign byp_data = '0;
`endif

    assign rd_pd       = ram_dout;
    assign rd_pvld     = reset_ && vld_pipe[2];
    assign fifo_cnt    = reset_ ? 8'(ram_cnt + {7'd0, s1_byp} + {7'd0, vld_pipe[2]}) : 8'd0;
    assign ram_we      = reset_ && we;
    assign ram_wa      = reset_ ? wr_ptr  : '0;
    assign ram_di      = reset_ ? wr_pd   : '0;
    assign ram_re      = re;
    assign ram_ra      = reset_ ? iss_ptr : '0;
    assign ram_ore     = reset_ && adv;
    assign ram_byp_sel = reset_ && s1_byp;
    assign ram_dbyp    = reset_ ? byp_data : '0;
endmodule

// File: tb/tb_sa_fifo_ctrl_rwsthp_80x17.sv
// Bench for sa_fifo_ctrl_rwsthp_80x17 with a behavioural model of the registered-read RAM.
// Expectations follow SA_FIFO_CTRL_BYPASS_EN when it is defined.
module tb_sa_fifo_ctrl_rwsthp_80x17;
    localparam int DEPTH = 80, WIDTH = 17, AW = 7;
`ifdef SA_FIFO_CTRL_BYPASS_EN
    localparam int N_FULL = 82, RISE = 2;
`else
    localparam int N_FULL = 81, RISE = 1;
`endif

    logic clk = 1'b0;
    logic reset_ = 1'b0, wr_pvld = 1'b0, rd_prdy = 1'b0;
    logic [WIDTH-1:0] wr_pd = '0;
    logic wr_prdy, rd_pvld, ram_re, ram_ore, ram_we, ram_byp_sel;
    logic [WIDTH-1:0] rd_pd, ram_di, ram_dbyp, ram_dout;
    logic [7:0] fifo_cnt;
    logic [AW-1:0] ram_ra, ram_wa;

    always #5 clk = ~clk;

    sa_fifo_ctrl_rwsthp_80x17 dut (
        .clk(clk), .reset_(reset_), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd), .fifo_cnt(fifo_cnt),
        .ram_ra(ram_ra), .ram_wa(ram_wa), .ram_re(ram_re), .ram_ore(ram_ore), .ram_we(ram_we),
        .ram_di(ram_di), .ram_dbyp(ram_dbyp), .ram_byp_sel(ram_byp_sel), .ram_dout(ram_dout)
    );

    // RAM: write port, address register on re, output register on ore
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] ra_d;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_d <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_d];
    end

    typedef struct {
        logic rn, pv; logic [WIDTH-1:0] pd; logic pr;
        logic e_wprdy, e_rpvld, e_we, e_re, e_ore, e_bsel;
        int e_cnt; logic chk_pd; logic [WIDTH-1:0] e_pd;
    } vec_t;
    vec_t vecs[$];

    int checks = 0, errors = 0, wa_wraps = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [AW-1:0] exp_wa = '0, exp_ra = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, pv, input logic [WIDTH-1:0] pd, input logic pr,
                       input logic wp, rv, we, re, ore, bs, input int cnt,
                       input logic cp, input logic [WIDTH-1:0] epd);
        vec_t v;
        v = '{rn, pv, pd, pr, wp, rv, we, re, ore, bs, cnt, cp, epd};
        vecs.push_back(v);
    endtask

    // One clock: drive after negedge, sample 1ns later, score pushes/pops and RAM pointers.
    task automatic cycle(input logic rn, pv, input logic [WIDTH-1:0] d, input logic pr,
                         output logic acc, output logic pop);
        @(negedge clk);
        reset_ = rn; wr_pvld = pv; wr_pd = d; rd_prdy = pr;
        #1;
        acc = wr_pvld && wr_prdy;
        pop = rd_pvld && rd_prdy;
        if (acc) exp_q.push_back(d);
        if (pop) begin
            if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
            else chk("pop_data", int'(rd_pd), int'(exp_q.pop_front()));
        end
        if (ram_we) begin
            chk("ram_wa", int'(ram_wa), int'(exp_wa));
            if (exp_wa == AW'(DEPTH - 1)) begin exp_wa = '0; wa_wraps++; end
            else exp_wa = exp_wa + 1'b1;
        end
        if (ram_re) begin
            chk("ram_ra", int'(ram_ra), int'(exp_ra));
            exp_ra = (exp_ra == AW'(DEPTH - 1)) ? '0 : exp_ra + 1'b1;
        end
        if (!rn) begin exp_q.delete(); exp_wa = '0; exp_ra = '0; end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc, pop, pr, hit, got;
        int k, sent, popped;

        //   rn pv pd        pr  wp rv we re ore bs cnt chk pd
        add(0, 0, 17'h0,     0,  0, 0, 0, 0, 0, 0, 0,  0, 17'h0);
        add(0, 0, 17'h0,     0,  0, 0, 0, 0, 0, 0, 0,  0, 17'h0);
`ifdef SA_FIFO_CTRL_BYPASS_EN
        add(1, 1, 17'h1ABCD, 1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 1, 1, 1,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 0, 0, 1,  1, 17'h1ABCD);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
        add(1, 1, 17'h00001, 1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
        add(1, 1, 17'h1FFFF, 1,  1, 0, 0, 0, 1, 1, 1,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 1, 1, 2,  1, 17'h00001);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 0, 0, 1,  1, 17'h1FFFF);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
`else
        add(1, 1, 17'h1ABCD, 1,  1, 0, 1, 0, 0, 0, 0,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 0, 0, 1, 0, 0, 1,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 1, 0, 1,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 0, 0, 1,  1, 17'h1ABCD);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
        add(1, 1, 17'h00001, 1,  1, 0, 1, 0, 0, 0, 0,  0, 17'h0);
        add(1, 1, 17'h1FFFF, 1,  1, 0, 1, 1, 0, 0, 1,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 0, 0, 1, 1, 0, 2,  0, 17'h0);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 1, 0, 2,  1, 17'h00001);
        add(1, 0, 17'h0,     1,  1, 1, 0, 0, 0, 0, 1,  1, 17'h1FFFF);
        add(1, 0, 17'h0,     1,  1, 0, 0, 0, 0, 0, 0,  0, 17'h0);
`endif
        foreach (vecs[i]) begin
            cycle(vecs[i].rn, vecs[i].pv, vecs[i].pd, vecs[i].pr, acc, pop);
            chk($sformatf("v%0d.wr_prdy", i),     int'(wr_prdy),     int'(vecs[i].e_wprdy));
            chk($sformatf("v%0d.rd_pvld", i),     int'(rd_pvld),     int'(vecs[i].e_rpvld));
            chk($sformatf("v%0d.ram_we", i),      int'(ram_we),      int'(vecs[i].e_we));
            chk($sformatf("v%0d.ram_re", i),      int'(ram_re),      int'(vecs[i].e_re));
            chk($sformatf("v%0d.ram_ore", i),     int'(ram_ore),     int'(vecs[i].e_ore));
            chk($sformatf("v%0d.ram_byp_sel", i), int'(ram_byp_sel), int'(vecs[i].e_bsel));
            chk($sformatf("v%0d.fifo_cnt", i),    int'(fifo_cnt),    vecs[i].e_cnt);
            if (vecs[i].chk_pd) chk($sformatf("v%0d.rd_pd", i), int'(rd_pd), int'(vecs[i].e_pd));
        end

        // Fill with rd_prdy low until push is refused.
        cycle(0, 0, '0, 0, acc, pop);
        k = 0;
        for (int n = 0; n < 200; n++) begin
            cycle(1, 1, WIDTH'(k), 0, acc, pop);
            if (acc) k++; else break;
        end
        chk("fill_count", k, N_FULL);
        chk("full_wr_prdy", int'(wr_prdy), 0);
        chk("full_fifo_cnt", int'(fifo_cnt), N_FULL);
        cycle(1, 1, 17'h12345, 0, acc, pop);
        chk("extra_push_refused", int'(acc), 0);
        chk("full_head", int'(rd_pd), 0);
        chk("full_rd_pvld", int'(rd_pvld), 1);

        // Push and pop together at full: push refused, drain one per cycle.
        cycle(1, 1, 17'h15555, 1, acc, pop);
        chk("simul_push_refused", int'(acc), 0);
        chk("simul_pop", int'(pop), 1);
        for (int i = 1; i < N_FULL; i++) begin
            cycle(1, 0, '0, 1, acc, pop);
            chk($sformatf("drain_pop%0d", i), int'(pop), 1);
            if (i < RISE)  chk("wr_prdy_still_low", int'(wr_prdy), 0);
            if (i == RISE) chk("wr_prdy_rise", int'(wr_prdy), 1);
        end
        cycle(1, 0, '0, 1, acc, pop);
        chk("drained_rd_pvld", int'(rd_pvld), 0);
        chk("drained_fifo_cnt", int'(fifo_cnt), 0);
        chk("drained_queue", exp_q.size(), 0);

        // Streaming with random back-pressure.
        sent = 0; popped = 0; wa_wraps = 0;
        for (int n = 0; n < 5000 && popped < 300; n++) begin
            pr = 1'($urandom_range(0, 1));
            cycle(1, sent < 300, WIDTH'(sent * 37 + 5), pr, acc, pop);
            if (acc) sent++;
            if (pop) popped++;
        end
        chk("stream_popped", popped, 300);
        chk("stream_wrapped", int'(wa_wraps >= 3), 1);

        // Reset mid-stream at fifo_cnt=40.
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            cycle(1, 1, WIDTH'(n + 17'h100), 0, acc, pop);
            hit = (fifo_cnt == 8'd40);
        end
        chk("reach_cnt40", int'(hit), 1);
        cycle(0, 0, '0, 0, acc, pop);
        chk("in_reset_wr_prdy", int'(wr_prdy), 0);
        chk("in_reset_fifo_cnt", int'(fifo_cnt), 0);
        cycle(1, 1, 17'h0AAAA, 1, acc, pop);
        chk("post_reset_fifo_cnt", int'(fifo_cnt), 0);
        chk("post_reset_rd_pvld", int'(rd_pvld), 0);
        chk("post_reset_wr_prdy", int'(wr_prdy), 1);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            cycle(1, 0, '0, 1, acc, pop);
            if (pop) begin
                got = 1'b1;
                chk("post_reset_first", int'(rd_pd), 17'h0AAAA);
            end
        end
        chk("post_reset_pop_seen", int'(got), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
